// File: rtl/vend_pay_ctrl.sv
// vend_pay_ctrl: N-product vending payment controller.
// Latches a product on start, credits one-hot coin pulses against its price,
// computes change or refund, and keeps saturating per-product sales counts
// plus a saturating revenue total.
module vend_pay_ctrl #(
    parameter int                   N_PROD = 4,
    parameter int                   MW     = 8,
    parameter int                   CW     = 4,
    parameter int                   RW     = 16,
    parameter logic [N_PROD*MW-1:0] PRICES = {8'd3, 8'd2, 8'd14, 8'd12}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_PROD-1:0]    sel,
    input  logic                 start,
    input  logic [3:0]           coin,
    input  logic                 cancel,
    input  logic                 ack,
    output logic                 busy,
    output logic [2:0]           prod_idx,
    output logic [MW-1:0]        remain,
    output logic [MW-1:0]        paid,
    output logic [MW-1:0]        change,
    output logic                 dispense,
    output logic                 refund,
    output logic                 coin_err,
    output logic [N_PROD*CW-1:0] sold,
    output logic [RW-1:0]        revenue
);

    typedef enum logic [1:0] {IDLE, PAY, DONE, REFUND} state_t;

    state_t                     state_q;
    logic [2:0]                 prod_idx_q;
    logic [MW-1:0]              paid_q;
    logic [MW-1:0]              change_q;
    logic                       dispense_q;
    logic                       coin_err_q;
    logic [N_PROD-1:0][CW-1:0]  sold_q;
    logic [RW-1:0]              revenue_q;

    logic [2:0]    sel_idx;
    logic          sel_any;
    logic [MW-1:0] price;
    logic [MW-1:0] denom;
    logic          coin_one;
    logic          coin_any;
    logic [MW-1:0] paid_d;
    logic [RW:0]   rev_sum;
    logic [RW-1:0] revenue_d;

    // Priority encode the select switches: lowest set index wins.
    always_comb begin
        sel_idx = '0;
        sel_any = |sel;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = 3'(i);
        end
    end

    // Price of the latched product.
    always_comb begin
        price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (prod_idx_q == 3'(i)) price = PRICES[i*MW +: MW];
        end
    end

    // Coin denomination; only a single set bit counts as a valid coin.
    always_comb begin
        denom    = '0;
        coin_one = 1'b1;
        coin_any = |coin;
        case (coin)
            4'b0001: denom = MW'(1);
            4'b0010: denom = MW'(2);
            4'b0100: denom = MW'(5);
            4'b1000: denom = MW'(10);
            default: coin_one = 1'b0;
        endcase
    end

    // Credit after this coin; prices are bounded so this cannot wrap.
    assign paid_d    = paid_q + denom;
    assign rev_sum   = {1'b0, revenue_q} + {{(RW + 1 - MW){1'b0}}, price};
    assign revenue_d = rev_sum[RW] ? {RW{1'b1}} : rev_sum[RW-1:0];

    // Purchase FSM with its registered outputs and sales bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prod_idx_q <= '0;
            paid_q     <= '0;
            change_q   <= '0;
            dispense_q <= 1'b0;
            coin_err_q <= 1'b0;
            sold_q     <= '0;
            revenue_q  <= '0;
        end else begin
            dispense_q <= 1'b0;
            coin_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    coin_err_q <= coin_any;
                    if (start && sel_any) begin
                        prod_idx_q <= sel_idx;
                        paid_q     <= '0;
                        state_q    <= PAY;
                    end
                end
                PAY: begin
                    if (cancel) begin
                        // Abort wins over any coin in the same cycle.
                        change_q <= paid_q;
                        state_q  <= REFUND;
                    end else if (coin_one) begin
                        paid_q <= paid_d;
                        if (paid_d >= price) begin
                            change_q   <= paid_d - price;
                            dispense_q <= 1'b1;
                            revenue_q  <= revenue_d;
                            state_q    <= DONE;
                            for (int i = 0; i < N_PROD; i++) begin
                                if (prod_idx_q == 3'(i) && sold_q[i] != {CW{1'b1}})
                                    sold_q[i] <= sold_q[i] + CW'(1);
                            end
                        end
                    end else if (coin_any) begin
                        coin_err_q <= 1'b1;
                    end
                end
                default: begin
                    // DONE and REFUND both wait for the customer to take things.
                    coin_err_q <= coin_any;
                    if (ack) begin
                        paid_q   <= '0;
                        change_q <= '0;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign prod_idx = prod_idx_q;
    assign remain   = (state_q == PAY) ? (price - paid_q) : '0;
    assign paid     = paid_q;
    assign change   = change_q;
    assign dispense = dispense_q;
    assign refund   = (state_q == REFUND);
    assign coin_err = coin_err_q;
    assign sold     = sold_q;
    assign revenue  = revenue_q;

endmodule
